stdp_weight_updater: RTL
========================

STDP_WEIGHT_UPDATER -- requirements
Module: stdp_weight_updater

Interface
REQ-001 Parameter NUM_SYN, default 16, number of synapses swept per update; power of 2, at least 2.
REQ-002 Parameter W_WIDTH, default 8, weight width (unsigned).
REQ-003 Parameter STEP, default 1, weight increment/decrement magnitude.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 update_req  input  1  start-sweep pulse; sampled in IDLE only.
REQ-007 busy  output  1  high from the cycle after acceptance until done.
REQ-008 done  output  1  one-cycle pulse at sweep completion.
REQ-009 syn_addr  output  log2(NUM_SYN)  synapse index for weight and timing memories.
REQ-010 rd_en  output  1  read strobe; data returns 1 cycle later.
REQ-011 wt_rd_data  input  W_WIDTH  weight read data.
REQ-012 td_rd_data  input  5 signed  spike-time-difference read data.
REQ-013 wr_en  output  1  weight write strobe at syn_addr.
REQ-014 wt_wr_data  output  W_WIDTH  updated weight.
REQ-015 time_difference  output  5 signed  registered timing value driven to the calcium-concentration block.
REQ-016 calcium_status  input  1  gate returned combinationally by the calcium block for the driven time_difference.
REQ-017 pot_count, dep_count  output  16 each  event counters (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, READ, EVAL, WRITE, DONE.
REQ-019 IDLE -> READ when update_req=1; syn_addr cleared to 0.
REQ-020 READ: rd_en=1 for exactly one cycle; -> EVAL.
REQ-021 EVAL: register wt_rd_data and td_rd_data; time_difference takes td_rd_data; -> WRITE.
REQ-022 WRITE: sample calcium_status.
REQ-023 WRITE update rule, part 1: calcium_status=1 and time_difference>0 -> weight+STEP, saturating at 2^W_WIDTH-1.
REQ-024 WRITE update rule, part 2: calcium_status=1 and time_difference<0 -> weight-STEP, saturating at 0.
REQ-025 wr_en=1 only when the new weight differs from the old weight; no write on zero difference, on calcium_status=0, or when already saturated.
REQ-026 After WRITE: if syn_addr=NUM_SYN-1 -> DONE, else syn_addr+1 and -> READ.
REQ-027 DONE: done=1 for one cycle; -> IDLE. Sweep latency SHALL be 3*NUM_SYN+1 cycles from acceptance to the done pulse.
REQ-028 update_req while not IDLE SHALL be ignored, with no queuing.
REQ-029 time_difference=-16 SHALL be treated as depression; time_difference=0 SHALL never modify a weight.
REQ-030 rd_en and wr_en SHALL never be asserted in the same cycle.

Reset
REQ-031 reset SHALL force the FSM to IDLE and set busy, done, rd_en, wr_en, syn_addr, time_difference, wt_wr_data, pot_count and dep_count to 0, asynchronously.
REQ-032 reset mid-sweep SHALL abort with no further writes; the next sweep restarts at syn_addr 0.

Configuration
REQ-033 With STDP_EVENT_COUNT_EN defined, pot_count increments on each potentiation write and dep_count on each depression write. Both saturate at 0xFFFF and clear only on reset.
REQ-034 Without STDP_EVENT_COUNT_EN, pot_count and dep_count SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-035 Package snn_plasticity_pkg SHALL hold the FSM state enum, the TD_WIDTH=5 constant and the default W_WIDTH.
REQ-036 The saturating step SHALL be the sub-module weight_step_sat: inputs weight, direction, enable; output new weight.

Verification
REQ-037 Reset, then update_req with all weights 100, all td=+3, calcium_status=1 -> 16 writes of 101; done at cycle 49; pot_count=16 when the macro is defined.
REQ-038 Weight 255, td=+2, calcium_status=1 -> no wr_en for that synapse; weight 0, td=-16, calcium_status=1 -> no wr_en.
REQ-039 td=-4, weight 50, calcium_status=1 -> write 49; same input with calcium_status=0 -> no write.
REQ-040 update_req pulsed during a sweep -> ignored; exactly one done pulse.
REQ-041 reset asserted at synapse 7 in EVAL -> outputs 0 immediately and no write; a new sweep starts at addr 0.
REQ-042 Build without STDP_EVENT_COUNT_EN -> pot_count and dep_count remain 0 throughout REQ-037.

Source files
------------

// File: rtl/snn_plasticity_pkg.sv
// Shared types and constants for the synaptic plasticity blocks.
// Holds the sweep FSM state encoding, timing-difference width and default weight width.
package snn_plasticity_pkg;

  localparam int TD_WIDTH        = 5;
  localparam int DEFAULT_W_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EVAL  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } stdp_state_e;

endpackage

// File: rtl/weight_step_sat.sv
// Saturating weight step: moves an unsigned weight up or down by STEP, clamping at
// the range limits. With enable low the weight passes through unchanged.
module weight_step_sat
  import snn_plasticity_pkg::*;
#(
  parameter int W_WIDTH = DEFAULT_W_WIDTH,
  parameter int STEP    = 1
) (
  input  logic [W_WIDTH-1:0] weight,
  input  logic               direction,
  input  logic               enable,
  output logic [W_WIDTH-1:0] new_weight
);

  localparam logic [W_WIDTH:0] MAX_W  = {1'b0, {W_WIDTH{1'b1}}};
  localparam logic [W_WIDTH:0] STEP_X = (W_WIDTH+1)'(STEP);

  logic [W_WIDTH:0] wide_w;
  logic [W_WIDTH:0] sum_w;
  logic [W_WIDTH:0] diff_w;

  always_comb begin
    wide_w     = {1'b0, weight};
    sum_w      = wide_w + STEP_X;
    diff_w     = wide_w - STEP_X;
    new_weight = weight;
    if (enable) begin
      // One extra bit of headroom lets both overflow and underflow be detected.
      if (direction) begin
        new_weight = (sum_w > MAX_W) ? MAX_W[W_WIDTH-1:0] : sum_w[W_WIDTH-1:0];
      end else begin
        new_weight = (wide_w < STEP_X) ? '0 : diff_w[W_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/stdp_weight_updater.sv
// STDP weight sweep: reads weight and spike-time difference per synapse, applies a
// calcium-gated saturating step, writes back changed weights. Optional event counters
// are enabled by defining STDP_EVENT_COUNT_EN.
module stdp_weight_updater
  import snn_plasticity_pkg::*;
#(
  parameter int NUM_SYN = 16,
  parameter int W_WIDTH = DEFAULT_W_WIDTH,
  parameter int STEP    = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       update_req,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_SYN)-1:0] syn_addr,
  output logic                       rd_en,
  input  logic [W_WIDTH-1:0]         wt_rd_data,
  input  logic signed [TD_WIDTH-1:0] td_rd_data,
  output logic                       wr_en,
  output logic [W_WIDTH-1:0]         wt_wr_data,
  output logic signed [TD_WIDTH-1:0] time_difference,
  input  logic                       calcium_status,
  output logic [15:0]                pot_count,
  output logic [15:0]                dep_count
);

  localparam int AW = $clog2(NUM_SYN);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_SYN - 1);

  stdp_state_e               state_q, state_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [W_WIDTH-1:0]        wt_q, wt_d;
  logic signed [TD_WIDTH-1:0] td_q, td_d;

  logic               step_en;
  logic               step_up;
  logic [W_WIDTH-1:0] step_wt;

  // Zero difference never steps; -16 falls on the negative side and depresses.
  always_comb begin
    step_up = (td_q > 0);
    step_en = calcium_status && (td_q != 0);
  end

  weight_step_sat #(
    .W_WIDTH (W_WIDTH),
    .STEP    (STEP)
  ) u_step (
    .weight     (wt_q),
    .direction  (step_up),
    .enable     (step_en),
    .new_weight (step_wt)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wt_d    = wt_q;
    td_d    = td_q;
    unique case (state_q)
      IDLE: begin
        if (update_req) begin
          state_d = READ;
          addr_d  = '0;
        end
      end
      READ:  state_d = EVAL;
      EVAL: begin
        wt_d    = wt_rd_data;
        td_d    = td_rd_data;
        state_d = WRITE;
      end
      WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wt_q    <= '0;
      td_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wt_q    <= wt_d;
      td_q    <= td_d;
    end
  end

  // Strobes decode straight from the state register so reset clears them at once.
  always_comb begin
    busy            = (state_q != IDLE);
    done            = (state_q == DONE);
    rd_en           = (state_q == READ);
    wr_en           = (state_q == WRITE) && (step_wt != wt_q);
    wt_wr_data      = (state_q == WRITE) ? step_wt : '0;
    syn_addr        = addr_q;
    time_difference = td_q;
  end

`ifdef STDP_EVENT_COUNT_EN
  logic [15:0] pot_q, pot_d;
  logic [15:0] dep_q, dep_d;

  always_comb begin
    pot_d = pot_q;
    dep_d = dep_q;
    if (wr_en) begin
      if (step_up) begin
        if (pot_q != 16'hFFFF) pot_d = pot_q + 16'd1;
      end else begin
        if (dep_q != 16'hFFFF) dep_d = dep_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pot_q <= '0;
      dep_q <= '0;
    end else begin
      pot_q <= pot_d;
      dep_q <= dep_d;
    end
  end

  assign pot_count = pot_q;
  assign dep_count = dep_q;
`else
  assign pot_count = '0;
  assign dep_count = '0;
`endif

endmodule
